// File: rtl/popcount_argmax_pkg.sv
// Shared types, default sizes and arithmetic helpers for the popcount argmax block.
package popcount_argmax_pkg;

  // Default sizes for the MNIST BNN output layer.
  localparam int unsigned DefNumClasses = 10;
  localparam int unsigned DefCntW       = 9;
  localparam int unsigned DefConfW      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // Returns a - b clamped to the all-ones value of a w-bit field (w < 32).
  // The caller guarantees a >= b, so the difference never wraps.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [31:0] diff;
    logic [31:0] lim;
    diff = a - b;
    lim  = (32'd1 << w) - 32'd1;
    return (diff > lim) ? lim : diff;
  endfunction

endpackage

// File: rtl/popcount_argmax_seq_top2_update.sv
// Combinational top-2 tracker step: folds one class value into the running max/runner-up.
// Kept standalone so a parallel reduction tree can reuse the same rule.
module top2_update
  import popcount_argmax_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned IDX_W = 4
) (
  input  logic [CNT_W-1:0] v,
  input  logic [IDX_W-1:0] ptr,
  input  logic [CNT_W-1:0] max,
  input  logic [CNT_W-1:0] second,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] max_nxt,
  output logic [CNT_W-1:0] second_nxt,
  output logic [IDX_W-1:0] idx_nxt
);

  // Strict compares keep the lowest index on ties; an equal later value becomes runner-up.
  always_comb begin
    max_nxt    = max;
    second_nxt = second;
    idx_nxt    = idx;
    if (ptr == '0) begin
      max_nxt    = v;
      second_nxt = '0;
      idx_nxt    = '0;
    end else if (v > max) begin
      second_nxt = max;
      max_nxt    = v;
      idx_nxt    = ptr;
    end else if (v > second) begin
      second_nxt = v;
    end
  end

endmodule

// File: rtl/popcount_argmax_seq.sv
// Serial argmax over a vector of class popcounts with a saturated confidence margin.
// Optional feature: define ARGMAX_TIE_FLAG_EN to add the tie_flag output.
module popcount_argmax_seq
  import popcount_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DefNumClasses,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned CONF_W      = DefConfW,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CLASSES*CNT_W-1:0] popcount_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             max_index,
  output logic [CONF_W-1:0]            confidence
`ifdef ARGMAX_TIE_FLAG_EN
  ,
  output logic                         tie_flag
`endif
);

  localparam int unsigned      VecW    = NUM_CLASSES * CNT_W;
  localparam logic [IDX_W-1:0] LastPtr = IDX_W'(NUM_CLASSES - 1);

  state_e           state_q;
  logic [VecW-1:0]  vec_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] second_q;
  // Set once the last class is folded in; the following cycle publishes the result.
  logic             last_q;

  logic [CNT_W-1:0]  cur_v;
  logic [CNT_W-1:0]  max_nxt;
  logic [CNT_W-1:0]  second_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [CONF_W-1:0] conf_sat;

  assign cur_v    = vec_q[ptr_q*CNT_W +: CNT_W];
  assign conf_sat = CONF_W'(sat_sub(32'(max_q), 32'(second_q), CONF_W));

  top2_update #(
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) u_top2_update (
    .v         (cur_v),
    .ptr       (ptr_q),
    .max       (max_q),
    .second    (second_q),
    .idx       (idx_q),
    .max_nxt   (max_nxt),
    .second_nxt(second_nxt),
    .idx_nxt   (idx_nxt)
  );

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      second_q   <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      max_index  <= '0;
      confidence <= '0;
`ifdef ARGMAX_TIE_FLAG_EN
      tie_flag   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            vec_q    <= popcount_in;
            ptr_q    <= '0;
            last_q   <= 1'b0;
            in_ready <= 1'b0;
            state_q  <= StScan;
          end
        end
        StScan: begin
          if (!last_q) begin
            max_q    <= max_nxt;
            second_q <= second_nxt;
            idx_q    <= idx_nxt;
            if (ptr_q == LastPtr) begin
              last_q <= 1'b1;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end else begin
            max_index  <= idx_q;
            confidence <= conf_sat;
`ifdef ARGMAX_TIE_FLAG_EN
            tie_flag   <= (second_q == max_q);
`endif
            out_valid  <= 1'b1;
            last_q     <= 1'b0;
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_argmax_seq.sv
// Directed self-checking bench for popcount_argmax_seq (default 10 x 9-bit configuration).
module tb_popcount_argmax_seq;

  localparam int unsigned N       = 10;
  localparam int unsigned W       = 9;
  localparam int          Latency = N + 1;
  localparam int          Budget  = 60;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N*W-1:0] popcount_in;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   max_index;
  logic [7:0]   confidence;
`ifdef ARGMAX_TIE_FLAG_EN
  logic         tie_flag;
`endif

  int checks = 0;
  int passed = 0;

  popcount_argmax_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .popcount_in(popcount_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .max_index  (max_index),
    .confidence (confidence)
`ifdef ARGMAX_TIE_FLAG_EN
    ,
    .tie_flag   (tie_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack(input int vals[N]);
    logic [N*W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = 9'(vals[i]);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until out_valid rises, giving up after Budget cycles.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < Budget) begin
      step();
      cyc++;
    end
  endtask

  // Sends one vector with out_ready high and checks latency, result and the one-cycle pulse.
  task automatic run_vector(input string name, input int vals[N], input int exp_idx,
                            input int exp_conf, input bit exp_tie);
    int cyc;
    out_ready   = 1'b1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_ready_before: got %b want 1", name, in_ready);
    else passed++;
    popcount_in = pack(vals);
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    popcount_in = '0;
    wait_valid(cyc);
    checks++;
    if (cyc !== Latency) $display("FAIL %s_latency: got %0d want %0d", name, cyc, Latency);
    else passed++;
    checks++;
    if (max_index !== 4'(exp_idx))
      $display("FAIL %s_index: got %0d want %0d", name, max_index, exp_idx);
    else passed++;
    checks++;
    if (confidence !== 8'(exp_conf))
      $display("FAIL %s_conf: got %0d want %0d", name, confidence, exp_conf);
    else passed++;
`ifdef ARGMAX_TIE_FLAG_EN
    checks++;
    if (tie_flag !== exp_tie) $display("FAIL %s_tie: got %b want %b", name, tie_flag, exp_tie);
    else passed++;
`else
    if (exp_tie) begin end
`endif
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_pulse: got valid=%b ready=%b want valid=0 ready=1", name, out_valid,
               in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    popcount_in = '1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
    checks++;
    if (max_index !== 4'd0) $display("FAIL reset_index: got %0d want 0", max_index);
    else passed++;
    checks++;
    if (confidence !== 8'd0) $display("FAIL reset_conf: got %0d want 0", confidence);
    else passed++;
`ifdef ARGMAX_TIE_FLAG_EN
    checks++;
    if (tie_flag !== 1'b0) $display("FAIL reset_tie: got %b want 0", tie_flag);
    else passed++;
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_max();
    int v[N];
    v = '{100, 100, 100, 100, 250, 100, 100, 100, 100, 100};
    run_vector("single", v, 4, 150, 1'b0);
  endtask

  task automatic test_tie();
    int v[N];
    v = '{100, 100, 200, 100, 100, 100, 200, 100, 100, 100};
    run_vector("tie", v, 2, 0, 1'b1);
  endtask

  task automatic test_generic();
    int v[N];
    v = '{50, 150, 200, 300, 100, 360, 250, 300, 150, 50};
    run_vector("generic", v, 5, 60, 1'b0);
  endtask

  task automatic test_saturation();
    int v[N];
    v = '{511, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_vector("saturate", v, 0, 255, 1'b0);
  endtask

  task automatic test_backpressure();
    int v[N];
    int cyc;
    v = '{20, 20, 20, 20, 20, 20, 20, 120, 20, 20};
    out_ready   = 1'b0;
    popcount_in = pack(v);
    in_valid    = 1'b1;
    step();
    // Competing vector held on the input while the result is stalled.
    v = '{10, 400, 10, 10, 10, 10, 10, 10, 10, 10};
    popcount_in = pack(v);
    wait_valid(cyc);
    checks++;
    if (cyc !== Latency) $display("FAIL bp_latency: got %0d want %0d", cyc, Latency);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || max_index !== 4'd7 || confidence !== 8'd100)
        $display("FAIL bp_hold%0d: got valid=%b ready=%b idx=%0d conf=%0d want 1 0 7 100", i,
                 out_valid, in_ready, max_index, confidence);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", out_valid,
               in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_accept: got ready=%b want 0", in_ready);
    else passed++;
    wait_valid(cyc);
    checks++;
    if (cyc !== Latency || max_index !== 4'd1 || confidence !== 8'd255)
      $display("FAIL bp_next: got cyc=%0d idx=%0d conf=%0d want %0d 1 255", cyc, max_index,
               confidence, Latency);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid_scan();
    int  v[N];
    bit  seen;
    v = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    out_ready   = 1'b1;
    popcount_in = pack(v);
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    // Three edges later the scan pointer sits at class 3.
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrst_state: got ready=%b valid=%b want ready=1 valid=0", in_ready,
               out_valid);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL midrst_no_output: got out_valid seen=%b want 0", seen);
    else passed++;
    v = '{50, 150, 200, 300, 100, 360, 250, 300, 150, 50};
    run_vector("after_rst", v, 5, 60, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_max();
    test_tie();
    test_generic();
    test_saturation();
    test_backpressure();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
